// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with
// round-robin arbitration and a single valid/ready response port.
// Exactly one operation is in flight: IDLE (arbitrate) -> ISSUE (ALU
// evaluates registered operands) -> RESP (response held until taken).
// Build option: define ALU_ARB_FLAGS_EN to capture and return the ALU's
// {C,V,N,Z} flags; without it rsp_flags is tied to zero and alu_flags is ignored.
module alu_arbiter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_op1,
  input  logic [width-1:0] req0_op2,
  input  logic [2:0]       req0_aluop,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_op1,
  input  logic [width-1:0] req1_op2,
  input  logic [2:0]       req1_aluop,
  output logic [width-1:0] alu_operand1,
  output logic [width-1:0] alu_operand2,
  output logic [2:0]       alu_op,
  input  logic [width-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [width-1:0] rsp_result,
  output logic [3:0]       rsp_flags
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [width-1:0] op1_q, op1_d;
  logic [width-1:0] op2_q, op2_d;
  logic [2:0]       aluop_q, aluop_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [width-1:0] rsp_result_q, rsp_result_d;
  logic             grant0, grant1;

  // Round-robin grant offered only while idle; last_grant_q=1 favours requester 0.
  always_comb begin
    grant0 = (state_q == S_IDLE) && req0_valid && (!req1_valid || last_grant_q);
    grant1 = (state_q == S_IDLE) && req1_valid && (!req0_valid || !last_grant_q);
  end

  // Next-state: latch the winner's operation, then capture the ALU output one cycle later.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    aluop_d      = aluop_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          op1_d        = grant1 ? req1_op1   : req0_op1;
          op2_d        = grant1 ? req1_op2   : req0_op2;
          aluop_d      = grant1 ? req1_aluop : req0_aluop;
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rsp_result_d = alu_result;
        rsp_valid_d  = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      aluop_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      aluop_q      <= aluop_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
  assign alu_op       = aluop_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = id_q;
  assign rsp_result   = rsp_result_q;

`ifdef ALU_ARB_FLAGS_EN
  logic [3:0] rsp_flags_q, rsp_flags_d;

  // Flags are captured together with the result and held until the response is taken.
  always_comb begin
    rsp_flags_d = rsp_flags_q;
    if (state_q == S_ISSUE) rsp_flags_d = alu_flags;
  end

  // Flag register.
  always_ff @(posedge clk) begin
    if (reset) rsp_flags_q <= '0;
    else       rsp_flags_q <= rsp_flags_d;
  end

  assign rsp_flags = rsp_flags_q;
`else
  logic unused_alu_flags;
  assign unused_alu_flags = ^alu_flags;
  assign rsp_flags        = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a bench-side 16-bit ALU
// (op 001 = ADD) and a transaction-level reference model.
module tb_alu_arbiter;

`ifdef ALU_ARB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]  req0_aluop, req1_aluop;
  logic [15:0] alu_operand1, alu_operand2, alu_result;
  logic [2:0]  alu_op;
  logic [3:0]  alu_flags;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.width(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_aluop(req0_aluop),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_aluop(req1_aluop),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  // Reference ALU: returns {C,V,N,Z,result}.
  function automatic logic [19:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0; w = '0; r = '0;
    case (op)
      3'b000: r = a & b;
      3'b001: begin
        w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'b010: begin
        w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: begin r = {a[14:0], 1'b0}; c = a[15]; end
      3'b110: begin r = {1'b0, a[15:1]}; c = a[0]; end
      default: r = b;
    endcase
    return {c, v, r[15], (r == 16'h0000), r};
  endfunction

  // Shared ALU instance driven by the arbiter.
  always_comb {alu_flags, alu_result} = ref_alu(alu_operand1, alu_operand2, alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_init = 1'b0;
  bit          m_busy, m_shown, m_last, m_id;
  logic [15:0] m_op1, m_op2, m_res;
  logic [2:0]  m_aop;
  logic [3:0]  m_flg;
  logic [19:0] m_r;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_init = 1'b1; m_busy = 1'b0; m_shown = 1'b0; m_last = 1'b1; m_id = 1'b0;
      m_op1 = '0; m_op2 = '0; m_aop = '0; m_res = '0; m_flg = '0;
    end else if (m_init) begin
      if (m_busy) begin
        if (!m_shown) m_shown = 1'b1;
        else if (rsp_ready) m_busy = 1'b0;
      end else if (req0_valid || req1_valid) begin
        m_id = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        m_last = m_id;
        m_op1 = m_id ? req1_op1 : req0_op1;
        m_op2 = m_id ? req1_op2 : req0_op2;
        m_aop = m_id ? req1_aluop : req0_aluop;
        m_r   = ref_alu(m_op1, m_op2, m_aop);
        m_res = m_r[15:0];
        m_flg = FLAGS_ON ? m_r[19:16] : 4'b0000;
        m_busy = 1'b1; m_shown = 1'b0;
      end
    end
  end

  bit e_r0, e_r1, e_v;

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
      e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
      e_v  = m_busy && m_shown;
      check("req0_ready", 32'(req0_ready), 32'(e_r0));
      check("req1_ready", 32'(req1_ready), 32'(e_r1));
      check("rsp_valid", 32'(rsp_valid), 32'(e_v));
      check("alu_operands", {alu_operand1, alu_operand2}, {m_op1, m_op2});
      check("alu_op", 32'(alu_op), 32'(m_aop));
      if (e_v) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_result", 32'(rsp_result), 32'(m_res));
        check("rsp_flags", 32'(rsp_flags), 32'(m_flg));
      end
      if (!FLAGS_ON) check("rsp_flags_tied", 32'(rsp_flags), 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  int unsigned gl[$];

  task automatic send(input bit who, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] op);
    bit ok;
    ok = 1'b0;
    if (!who) begin req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_aluop = op; end
    else      begin req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_aluop = op; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((!who && req0_ready) || (who && req1_ready)) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL send_timeout actual=no_grant required=grant"); end
    @(posedge clk); #1;
    if (!who) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 99;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; break; end
    end
    checks++;
    if (lat == 99) begin errors++; $display("FAIL rsp_timeout actual=no_rsp_valid required=rsp_valid"); end
  endtask

  task automatic consume();
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic drain();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_random(input int unsigned n, input int unsigned pv, input int unsigned pr);
    bit hs0, hs1;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (hs0) gl.push_back(0);
      if (hs1) gl.push_back(1);
      @(posedge clk); #1;
      if (hs0 || !req0_valid) begin
        req0_valid = ($urandom_range(99) < pv);
        req0_op1 = 16'($urandom); req0_op2 = 16'($urandom); req0_aluop = 3'($urandom_range(7));
      end
      if (hs1 || !req1_valid) begin
        req1_valid = ($urandom_range(99) < pv);
        req1_op1 = 16'($urandom); req1_op2 = 16'($urandom); req1_aluop = 3'($urandom_range(7));
      end
      rsp_ready = ($urandom_range(99) < pr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence, then random traffic ----------------
  initial begin
    int lat;
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_aluop = '0;
    req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_aluop = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_alu_outputs", {alu_operand1, alu_operand2}, 32'd0);
    check("reset_rsp_outputs",
          32'({alu_op, rsp_valid, rsp_id, rsp_result, rsp_flags, req0_ready, req1_ready}), 32'd0);
    check("model_add", 32'(ref_alu(16'h0029, 16'h0012, 3'b001)), 32'h0_003B);
    check("model_add_neg", 32'(ref_alu(16'h9819, 16'h0010, 3'b001)), 32'h2_9829);
    check("model_add_wrap", 32'(ref_alu(16'hFFFF, 16'h0001, 3'b001)), 32'h9_0000);

    // 1: single requester 0, latency two edges after the handshake
    @(posedge clk); #1 reset = 1'b0;
    send(1'b0, 16'h0029, 16'h0012, 3'b001);
    wait_rsp(lat);
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_result", 32'(rsp_result), 32'h003B);
    check("t1_flags", 32'(rsp_flags), 32'h0);
    consume();

    // 2: requester 1 alone, negative result
    send(1'b1, 16'h9819, 16'h0010, 3'b001);
    wait_rsp(lat);
    check("t2_id", 32'(rsp_id), 32'd1);
    check("t2_result", 32'(rsp_result), 32'h9829);
    check("t2_flags", 32'(rsp_flags), FLAGS_ON ? 32'h2 : 32'h0);
    consume();

    // 3: both requesting continuously with the consumer always ready
    gl.delete();
    run_random(16, 100, 100);
    while (gl.size() < 4) gl.push_back(9);
    for (int i = 0; i < 4; i++) check("t3_alternate", 32'(gl[i]), 32'(i % 2));
    drain();

    // 4: consumer stalls five cycles in RESP with both requesters waiting
    send(1'b0, 16'h1234, 16'h0FF0, 3'b001);
    wait_rsp(lat);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op1 = 16'h1111; req0_op2 = 16'h2222; req0_aluop = 3'b100;
    req1_valid = 1'b1; req1_op1 = 16'h3333; req1_op2 = 16'h0001; req1_aluop = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_result", 32'(rsp_result), 32'h2224);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("t4_idle_grant", 32'({req0_ready, req1_ready}), 32'b01);
    @(posedge clk); #1;
    drain();

    // 5: reset while the operation is in ISSUE
    send(1'b0, 16'h0101, 16'h0202, 3'b001);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid = 1'b1; req0_op1 = 16'h0005; req0_op2 = 16'h0007; req0_aluop = 3'b001;
    req1_valid = 1'b1; req1_op1 = 16'h0009; req1_op2 = 16'h0003; req1_aluop = 3'b001;
    @(negedge clk);
    check("t5_rsp_dropped", 32'(rsp_valid), 32'd0);
    check("t5_req0_wins", 32'({req0_ready, req1_ready}), 32'b10);
    @(posedge clk); #1;
    drain();

    // 6: carry-out wraps the result to zero
    send(1'b0, 16'hFFFF, 16'h0001, 3'b001);
    wait_rsp(lat);
    check("t6_result", 32'(rsp_result), 32'h0000);
    check("t6_flags", 32'(rsp_flags), FLAGS_ON ? 32'h9 : 32'h0);
    consume();

    // random traffic with back-pressure
    run_random(3000, 60, 70);
    drain();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
